// File: rtl/quantizer_pkg.sv
// Shared types and constants for the block quantizer: FSM state encoding and
// the symmetric quantization limit for a given output width.
package quantizer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MAX,
    ST_DIV,
    ST_MUL,
    ST_OUT
  } state_e;

  function automatic int qmax(input int out_width);
    return (1 << (out_width - 1)) - 1;
  endfunction

endpackage

// File: rtl/fixed_recip_divider.sv
// Sequential restoring divider: one quotient bit per clock after a start pulse,
// with a single-cycle done pulse once all DIVIDEND_W bits are resolved.
module fixed_recip_divider #(
  parameter int DIVIDEND_W = 23,
  parameter int DIVISOR_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  done,
  output logic [DIVIDEND_W-1:0] quotient
);

  localparam int CNT_W = $clog2(DIVIDEND_W + 1);

  logic [DIVISOR_W-1:0]  rem_q, rem_d;
  logic [DIVIDEND_W-1:0] sh_q, sh_d;
  logic [DIVISOR_W-1:0]  dsr_q, dsr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [DIVISOR_W:0]    trial;
  logic                  fits;

  // sh_q shifts dividend bits out of its top while quotient bits enter at the bottom
  always_comb begin
    rem_d  = rem_q;
    sh_d   = sh_q;
    dsr_d  = dsr_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;
    trial  = {rem_q, sh_q[DIVIDEND_W-1]};
    fits   = (trial >= {1'b0, dsr_q});
    if (start) begin
      rem_d  = '0;
      sh_d   = dividend;
      dsr_d  = divisor;
      cnt_d  = CNT_W'(DIVIDEND_W);
      busy_d = 1'b1;
    end else if (busy_q) begin
      rem_d = fits ? DIVISOR_W'(trial - {1'b0, dsr_q}) : DIVISOR_W'(trial);
      sh_d  = {sh_q[DIVIDEND_W-2:0], fits};
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == CNT_W'(1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q  <= '0;
      sh_q   <= '0;
      dsr_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      sh_q   <= sh_d;
      dsr_q  <= dsr_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign done     = done_q;
  assign quotient = sh_q;

endmodule

// File: rtl/fixed_block_quantizer.sv
// Block quantizer: scales a beat of signed elements by QMAX/max|x| into OUT_WIDTH
// symmetric values. Define FIXED_BLOCK_QUANTIZER_ROUND_EN for round-half-up, else floor.
module fixed_block_quantizer
  import quantizer_pkg::*;
#(
  parameter int IN_WIDTH    = 16,
  parameter int IN_SIZE     = 4,
  parameter int OUT_WIDTH   = 8,
  parameter int RECIP_WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic signed [IN_WIDTH-1:0]  data_in [IN_SIZE],
  input  logic                        data_in_valid,
  output logic                        data_in_ready,
  output logic signed [OUT_WIDTH-1:0] data_out [IN_SIZE],
  output logic [IN_WIDTH-1:0]         data_out_max_num,
  output logic                        data_out_valid,
  input  logic                        data_out_ready
);

  localparam int QMAX   = qmax(OUT_WIDTH);
  localparam int D      = OUT_WIDTH - 1 + RECIP_WIDTH;
  localparam int PROD_W = IN_WIDTH + D + 1;
  localparam logic [D-1:0] DIVIDEND = D'(QMAX) << RECIP_WIDTH;
  localparam logic signed [PROD_W-1:0] QMAX_S = PROD_W'(QMAX);
  localparam logic signed [PROD_W-1:0] NQMAX_S = -QMAX_S;

  state_e                      state_q, state_d;
  logic signed [IN_WIDTH-1:0]  data_q [IN_SIZE];
  logic signed [IN_WIDTH-1:0]  data_d [IN_SIZE];
  logic signed [OUT_WIDTH-1:0] out_q [IN_SIZE];
  logic signed [OUT_WIDTH-1:0] out_d [IN_SIZE];
  logic [IN_WIDTH-1:0]         max_abs_q, max_abs_d;
  logic [IN_WIDTH-1:0]         mag_c [IN_SIZE];
  logic [IN_WIDTH-1:0]         max_abs_c;
  logic signed [PROD_W-1:0]    prod_c [IN_SIZE];
  logic signed [PROD_W-1:0]    shifted_c [IN_SIZE];
  logic signed [OUT_WIDTH-1:0] y_c [IN_SIZE];
  logic [D-1:0]                recip_c;
  logic [D-1:0]                div_quotient;
  logic                        div_start;
  logic                        div_done;

  fixed_recip_divider #(
    .DIVIDEND_W(D),
    .DIVISOR_W (IN_WIDTH)
  ) u_divider (
    .clk     (clk),
    .rst     (rst),
    .start   (div_start),
    .dividend(DIVIDEND),
    .divisor (max_abs_c),
    .done    (div_done),
    .quotient(div_quotient)
  );

  // Magnitudes are unsigned, so the most negative input maps to 2^(IN_WIDTH-1) without wrapping
  always_comb begin
    max_abs_c = '0;
    for (int i = 0; i < IN_SIZE; i++) begin
      mag_c[i] = data_q[i][IN_WIDTH-1] ? (~unsigned'(data_q[i]) + IN_WIDTH'(1))
                                       : unsigned'(data_q[i]);
      if (mag_c[i] > max_abs_c) max_abs_c = mag_c[i];
    end
  end

  assign recip_c = (max_abs_q == '0) ? '0 : div_quotient;

  always_comb begin
    for (int i = 0; i < IN_SIZE; i++) begin
`ifdef FIXED_BLOCK_QUANTIZER_ROUND_EN
      prod_c[i] = PROD_W'(data_q[i]) * $signed({{(PROD_W - D){1'b0}}, recip_c})
                + $signed({{(PROD_W - RECIP_WIDTH){1'b0}}, 1'b1, {(RECIP_WIDTH - 1){1'b0}}});
`else
      prod_c[i] = PROD_W'(data_q[i]) * $signed({{(PROD_W - D){1'b0}}, recip_c});
`endif
      shifted_c[i] = prod_c[i] >>> RECIP_WIDTH;
      if (shifted_c[i] > QMAX_S)       y_c[i] = OUT_WIDTH'(QMAX_S);
      else if (shifted_c[i] < NQMAX_S) y_c[i] = OUT_WIDTH'(NQMAX_S);
      else                             y_c[i] = OUT_WIDTH'(shifted_c[i]);
    end
  end

  // An all-zero beat passes through DIV for one cycle without starting the divider
  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    out_d     = out_q;
    max_abs_d = max_abs_q;
    div_start = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (data_in_valid) begin
          data_d  = data_in;
          state_d = ST_MAX;
        end
      end
      ST_MAX: begin
        max_abs_d = max_abs_c;
        div_start = (max_abs_c != '0);
        state_d   = ST_DIV;
      end
      ST_DIV: begin
        if (max_abs_q == '0 || div_done) state_d = ST_MUL;
      end
      ST_MUL: begin
        out_d   = y_c;
        state_d = ST_OUT;
      end
      ST_OUT: begin
        if (data_out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      data_q    <= '{default: '0};
      out_q     <= '{default: '0};
      max_abs_q <= '0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      out_q     <= out_d;
      max_abs_q <= max_abs_d;
    end
  end

  assign data_in_ready    = (state_q == ST_IDLE);
  assign data_out_valid   = (state_q == ST_OUT);
  assign data_out         = out_q;
  assign data_out_max_num = max_abs_q;

endmodule

// File: tb/tb_fixed_block_quantizer.sv
// Directed self-checking bench for fixed_block_quantizer; expected values are
// hand-computed for both the rounding and truncating builds.
module tb_fixed_block_quantizer;

`ifdef FIXED_BLOCK_QUANTIZER_ROUND_EN
  localparam bit ROUND = 1'b1;
`else
  localparam bit ROUND = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic signed [15:0] data_in [4];
  logic              data_in_valid;
  logic              data_in_ready;
  logic signed [7:0] data_out [4];
  logic [15:0]       data_out_max_num;
  logic              data_out_valid;
  logic              data_out_ready;

  int check_count = 0;
  int pass_count  = 0;
  int fail_count  = 0;
  int latency     = 0;
  int quiet_edges = 0;

  fixed_block_quantizer #(
    .IN_WIDTH   (16),
    .IN_SIZE    (4),
    .OUT_WIDTH  (8),
    .RECIP_WIDTH(16)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .data_in         (data_in),
    .data_in_valid   (data_in_valid),
    .data_in_ready   (data_in_ready),
    .data_out        (data_out),
    .data_out_max_num(data_out_max_num),
    .data_out_valid  (data_out_valid),
    .data_out_ready  (data_out_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkVal(input string tag, input logic signed [31:0] obs,
                          input logic signed [31:0] exp);
    check_count++;
    assert (obs === exp) pass_count++;
    else begin
      fail_count++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Offer one beat, then count edges after the accepting edge until valid appears
  task automatic applyStimulus(input logic signed [15:0] e0, e1, e2, e3);
    data_in[0] = e0;
    data_in[1] = e1;
    data_in[2] = e2;
    data_in[3] = e3;
    data_in_valid = 1'b1;
    @(posedge clk);
    #1;
    data_in_valid = 1'b0;
    latency = 0;
    while (!data_out_valid && latency < 100) begin
      @(posedge clk);
      #1;
      latency++;
    end
  endtask

  task automatic checkOutput(input string tag, input int exp_lat, input int exp_max,
                             input int y0, y1, y2, y3);
    checkVal({tag, ".latency"}, latency, exp_lat);
    checkVal({tag, ".max_num"}, {16'd0, data_out_max_num}, exp_max);
    checkVal({tag, ".y0"}, data_out[0], y0);
    checkVal({tag, ".y1"}, data_out[1], y1);
    checkVal({tag, ".y2"}, data_out[2], y2);
    checkVal({tag, ".y3"}, data_out[3], y3);
    data_out_ready = 1'b1;
    @(posedge clk);
    #1;
    data_out_ready = 1'b0;
    checkVal({tag, ".valid_after"}, data_out_valid, 0);
    checkVal({tag, ".ready_after"}, data_in_ready, 1);
  endtask

  initial begin
    rst            = 1'b1;
    data_in_valid  = 1'b0;
    data_out_ready = 1'b0;
    for (int i = 0; i < 4; i++) data_in[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    checkVal("reset.valid", data_out_valid, 0);
    checkVal("reset.max_num", {16'd0, data_out_max_num}, 0);
    checkVal("reset.y0", data_out[0], 0);
    checkVal("reset.y3", data_out[3], 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkVal("reset.ready", data_in_ready, 1);

    applyStimulus(16'sd1000, -16'sd500, 16'sd250, 16'sd0);
    checkOutput("beat_1000", 26, 1000, ROUND ? 127 : 126, ROUND ? -63 : -64,
                ROUND ? 32 : 31, 0);

    applyStimulus(16'sd0, 16'sd0, 16'sd0, 16'sd0);
    checkOutput("beat_zero", 3, 0, 0, 0, 0, 0);

    applyStimulus(-16'sd32768, 16'sd16384, 16'sd1, -16'sd1);
    checkOutput("beat_minneg", 26, 32768, -127, ROUND ? 64 : 63, 0, ROUND ? 0 : -1);

    applyStimulus(16'sd100, -16'sd100, 16'sd50, -16'sd25);
    checkOutput("beat_100", 26, 100, ROUND ? 127 : 126, -127, 63, -32);

    applyStimulus(16'sd1, 16'sd0, -16'sd1, 16'sd1);
    checkOutput("beat_unit", 26, 1, 127, 0, -127, 127);

    // Stall in OUT while a competing beat is offered
    applyStimulus(16'sd1000, -16'sd500, 16'sd250, 16'sd0);
    for (int k = 0; k < 10; k++) begin
      if (k == 3) begin
        for (int i = 0; i < 4; i++) data_in[i] = 16'sd5;
        data_in_valid = 1'b1;
      end
      @(posedge clk);
      #1;
      checkVal("stall.valid", data_out_valid, 1);
      checkVal("stall.in_ready", data_in_ready, 0);
      checkVal("stall.y0", data_out[0], ROUND ? 127 : 126);
      checkVal("stall.y1", data_out[1], ROUND ? -63 : -64);
    end
    data_in_valid = 1'b0;
    checkOutput("stall_beat", 26, 1000, ROUND ? 127 : 126, ROUND ? -63 : -64,
                ROUND ? 32 : 31, 0);

    // Reset while the divider is working
    data_in[0] = 16'sd1000;
    data_in[1] = -16'sd500;
    data_in[2] = 16'sd250;
    data_in[3] = 16'sd0;
    data_in_valid = 1'b1;
    @(posedge clk);
    #1;
    data_in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checkVal("middiv.valid", data_out_valid, 0);
    checkVal("middiv.y0", data_out[0], 0);
    checkVal("middiv.max_num", {16'd0, data_out_max_num}, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkVal("middiv.ready", data_in_ready, 1);
    quiet_edges = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk);
      #1;
      if (!data_out_valid) quiet_edges++;
    end
    checkVal("middiv.no_output", quiet_edges, 30);

    applyStimulus(-16'sd32768, 16'sd16384, 16'sd1, -16'sd1);
    checkOutput("after_reset", 26, 32768, -127, ROUND ? 64 : 63, 0, ROUND ? 0 : -1);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
